// File: rtl/spike_event_recorder_pkg.sv
// Shared definitions for spike_event_recorder: default parameters and event word layout.
// The optional ISI field is controlled by the SPIKE_ISI_EN macro.
package spike_event_recorder_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_TS_W     = 32;
    localparam int unsigned DEF_DEPTH    = 16;
    localparam int          DEF_V_THRESH = 30;
    localparam int unsigned DEF_DROP_W   = 8;

`ifdef SPIKE_ISI_EN
    localparam bit ISI_EN = 1'b1;
`else
    localparam bit ISI_EN = 1'b0;
`endif

    // Event word layout, LSB first: u, timestamp, then ISI when present.
    // An ISI of all-ones marks the first stored spike, which has no predecessor.
    function automatic int unsigned evt_ts_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned evt_isi_lsb(input int unsigned data_w, input int unsigned ts_w);
        return data_w + ts_w;
    endfunction

    function automatic int unsigned evt_word_w(input int unsigned data_w, input int unsigned ts_w,
                                               input bit isi_en);
        return isi_en ? (data_w + 2 * ts_w) : (data_w + ts_w);
    endfunction

endpackage

// File: rtl/spike_event_recorder_fifo.sv
// Synchronous FIFO with a registered head word; pointers carry an extra MSB for full/empty.
module spike_event_recorder_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_wr_ptr_n;
    logic [PW-1:0]    w_rd_ptr_n;
    logic             w_do_push;
    logic             w_do_pop;

    // o_valid is the registered "not empty" flag, so it gates pops directly.
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop   = i_pop & o_valid;
    assign w_do_push  = i_push & (~o_full | w_do_pop);
    assign w_rd_ptr_n = r_rd_ptr + PW'(w_do_pop);
    assign w_wr_ptr_n = r_wr_ptr + PW'(w_do_push);

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Pointer update and head register preload (write-through when the FIFO refills from empty).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_n;
            r_rd_ptr <= w_rd_ptr_n;
            o_valid  <= (w_rd_ptr_n != w_wr_ptr_n);
            if (w_do_push && (r_wr_ptr == w_rd_ptr_n)) begin
                o_data <= i_data;
            end else if (w_rd_ptr_n != w_wr_ptr_n) begin
                o_data <= r_mem[w_rd_ptr_n[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/spike_event_recorder.sv
// On-chip spike capture for the AdEx neuron: threshold-crossing detector, free-running
// timestamp, event FIFO and saturating drop counter. Define SPIKE_ISI_EN to add evt_isi.
module spike_event_recorder
    import spike_event_recorder_pkg::*;
#(
    parameter int unsigned              DATA_W   = DEF_DATA_W,
    parameter int unsigned              TS_W     = DEF_TS_W,
    parameter int unsigned              DEPTH    = DEF_DEPTH,
    parameter logic signed [DATA_W-1:0] V_THRESH = DATA_W'(DEF_V_THRESH),
    parameter int unsigned              DROP_W   = DEF_DROP_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] v,
    input  logic signed [DATA_W-1:0] u,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_time,
    output logic signed [DATA_W-1:0] evt_u,
    output logic [DROP_W-1:0]        drop_cnt
`ifdef SPIKE_ISI_EN
    ,
    output logic [TS_W-1:0]          evt_isi
`endif
);

    localparam int unsigned WORD_W = evt_word_w(DATA_W, TS_W, ISI_EN);
    localparam int unsigned TS_LSB = evt_ts_lsb(DATA_W);

    logic [TS_W-1:0]   r_ts_cnt;
    logic              r_above_q;
    logic [DROP_W-1:0] r_drop_cnt;
    logic              w_above;
    logic              w_spike;
    logic              w_pop;
    logic              w_full;
    logic              w_drop;
    logic [WORD_W-1:0] w_push_word;
    logic [WORD_W-1:0] w_head_word;

    assign w_above = (v >= V_THRESH);
    assign w_spike = en & w_above & ~r_above_q;
    assign w_pop   = evt_valid & evt_ready;
    assign w_drop  = w_spike & w_full & ~w_pop;

    // Timestamp counter and previous-sample comparator state; above_q resets high to mask the first sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts_cnt  <= '0;
            r_above_q <= 1'b1;
        end else begin
            r_ts_cnt  <= r_ts_cnt + TS_W'(1);
            r_above_q <= w_above;
        end
    end

    // Count spikes lost to a full FIFO, holding at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end
    end

`ifdef SPIKE_ISI_EN
    localparam int unsigned ISI_LSB = evt_isi_lsb(DATA_W, TS_W);

    logic [TS_W-1:0] r_last_ts;
    logic            r_have_prev;
    logic            w_push_ok;
    logic [TS_W-1:0] w_isi;

    assign w_push_ok = w_spike & (~w_full | w_pop);
    assign w_isi     = r_have_prev ? (r_ts_cnt - r_last_ts) : '1;

    // Remember the timestamp of the last spike that actually entered the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_ts   <= '0;
            r_have_prev <= 1'b0;
        end else if (w_push_ok) begin
            r_last_ts   <= r_ts_cnt;
            r_have_prev <= 1'b1;
        end
    end

    assign w_push_word = {w_isi, r_ts_cnt, u};
    assign evt_isi     = w_head_word[ISI_LSB +: TS_W];
`else
    assign w_push_word = {r_ts_cnt, u};
`endif

    spike_event_recorder_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_spike),
        .i_pop   (evt_ready),
        .i_data  (w_push_word),
        .o_valid (evt_valid),
        .o_data  (w_head_word),
        .o_full  (w_full)
    );

    assign evt_time = w_head_word[TS_LSB +: TS_W];
    assign evt_u    = w_head_word[DATA_W-1:0];
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_spike_event_recorder.sv
// Bench for spike_event_recorder: queue-based event model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic. ISI checks need SPIKE_ISI_EN.
module tb_spike_event_recorder;

    localparam int DEPTH = 16;
    localparam int V_TH  = 30;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic signed [15:0] v;
    logic signed [15:0] u;
    logic               evt_valid;
    logic               evt_ready;
    logic [31:0]        evt_time;
    logic [15:0]        evt_u;
    logic [7:0]         drop_cnt;
`ifdef SPIKE_ISI_EN
    logic [31:0]        evt_isi;
`endif

    spike_event_recorder dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .v         (v),
        .u         (u),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_time  (evt_time),
        .evt_u     (evt_u),
        .drop_cnt  (drop_cnt)
`ifdef SPIKE_ISI_EN
        ,
        .evt_isi   (evt_isi)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] t;
        logic [15:0] u;
        logic [31:0] isi;
    } evt_t;

    // Model state: what the recorder must hold after each edge.
    evt_t        m_q[$];
    logic [31:0] m_ts;
    bit          m_above_q;
    int          m_drop;
    bit          m_have_prev;
    logic [31:0] m_last;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one clock edge worth of spec rules to the model.
    task automatic model_edge();
        bit   pop;
        bit   above;
        bit   spike;
        evt_t e;
        if (reset) begin
            m_q.delete();
            m_ts        = '0;
            m_above_q   = 1'b1;
            m_drop      = 0;
            m_have_prev = 1'b0;
            m_last      = '0;
        end else begin
            pop       = (m_q.size() > 0) && evt_ready;
            above     = (int'(v) >= V_TH);
            spike     = en && above && !m_above_q;
            m_above_q = above;
            if (pop) void'(m_q.pop_front());
            if (spike) begin
                if (m_q.size() < DEPTH) begin
                    e.t   = m_ts;
                    e.u   = u;
                    e.isi = m_have_prev ? (m_ts - m_last) : 32'hFFFF_FFFF;
                    m_q.push_back(e);
                    m_have_prev = 1'b1;
                    m_last      = m_ts;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            m_ts = m_ts + 32'd1;
        end
    endtask

    task automatic compare();
        chk("evt_valid", 64'(evt_valid), 64'(m_q.size() != 0));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (m_q.size() != 0) begin
            chk("evt_time", 64'(evt_time), 64'(m_q[0].t));
            chk("evt_u", 64'(evt_u), 64'(m_q[0].u));
`ifdef SPIKE_ISI_EN
            chk("evt_isi", 64'(evt_isi), 64'(m_q[0].isi));
`endif
        end
    endtask

    // Drive inputs at the falling edge, step the model on the rising edge, compare 1 ns later.
    task automatic cyc(input bit rst, input bit e, input bit rdy, input int vv, input int uu);
        reset     = rst;
        en        = e;
        evt_ready = rdy;
        v         = 16'(vv);
        u         = 16'(uu);
        @(posedge clk);
        model_edge();
        #1;
        compare();
        @(negedge clk);
    endtask

    initial begin
        int n;
        int vv;
        bit r;
        int rp;

        // Reset state and quiet input.
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_time", 64'(evt_time), 64'd0);
        chk("rst_u", 64'(evt_u), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 100; i++) cyc(0, 1, 1, 0, int'($urandom_range(0, 65535)));
        chk("t1_valid", 64'(evt_valid), 64'd0);
        chk("t1_drop", 64'(drop_cnt), 64'd0);

        // High from the first sample is masked; crossing at ts=12 shows up one cycle later.
        cyc(1, 1, 0, 0, 0);
        for (int c = 0; c < 12; c++) cyc(0, 1, 0, (c == 11) ? 0 : 40, c * 3 + 5);
        chk("t2_no_early", 64'(evt_valid), 64'd0);
        cyc(0, 1, 0, 40, 41);
        chk("t2_valid", 64'(evt_valid), 64'd1);
        chk("t2_time", 64'(evt_time), 64'd12);
        chk("t2_u", 64'(evt_u), 64'd41);
        cyc(0, 1, 1, 40, 0);
        chk("t2_popped", 64'(evt_valid), 64'd0);

        // 20 crossings into a 16-deep FIFO with no consumer.
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1, 0, 40, 1000 + k);
            cyc(0, 1, 0, 0, 0);
        end
        chk("t3_drop", 64'(drop_cnt), 64'd4);
        for (int k = 0; k < 16; k++) begin
            chk("t3_order", 64'(evt_time), 64'(1 + 2 * k));
            cyc(0, 1, 1, 0, 0);
        end
        chk("t3_empty", 64'(evt_valid), 64'd0);

        // Full FIFO with a push and a pop on the same edge loses nothing.
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            cyc(0, 1, 0, 40, k);
            cyc(0, 1, 0, 0, 0);
        end
        chk("t4_drop_full", 64'(drop_cnt), 64'd0);
        cyc(0, 1, 1, 40, 77);
        chk("t4_drop_pp", 64'(drop_cnt), 64'd0);
        n = 0;
        for (int i = 0; i < 40 && evt_valid; i++) begin
            n++;
            cyc(0, 1, 1, 0, 0);
        end
        chk("t4_count", 64'(n), 64'd16);

        // Enabling while already above threshold must not spike.
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 40, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 40, 0);
        chk("t5_none", 64'(evt_valid), 64'd0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 40, 9);
        chk("t5_valid", 64'(evt_valid), 64'd1);
        chk("t5_time", 64'(evt_time), 64'd12);

        // Drop counter saturates.
        cyc(1, 1, 0, 0, 0);
        for (int k = 0; k < 300; k++) begin
            cyc(0, 1, 0, 0, 0);
            cyc(0, 1, 0, 40, 0);
        end
        chk("t7_sat", 64'(drop_cnt), 64'd255);

`ifdef SPIKE_ISI_EN
        // ISI of crossings at ts 10, 25, 100.
        cyc(1, 1, 0, 0, 0);
        for (int c = 0; c <= 110; c++) cyc(0, 1, 0, (c == 10 || c == 25 || c == 100) ? 40 : 0, c);
        chk("t6_isi0", 64'(evt_isi), 64'hFFFF_FFFF);
        cyc(0, 1, 1, 0, 0);
        chk("t6_isi1", 64'(evt_isi), 64'd15);
        cyc(0, 1, 1, 0, 0);
        chk("t6_isi2", 64'(evt_isi), 64'd75);
        chk("t6_time2", 64'(evt_time), 64'd100);
        cyc(0, 1, 1, 40, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 40, 0);
        cyc(1, 1, 0, 40, 0);
        chk("t6_rst_valid", 64'(evt_valid), 64'd0);
        for (int c = 0; c <= 5; c++) cyc(0, 1, 0, (c == 5) ? 40 : 0, 0);
        chk("t6_restart_t", 64'(evt_time), 64'd5);
        chk("t6_restart_i", 64'(evt_isi), 64'hFFFF_FFFF);
`endif

        // Randomized traffic with varying consumer pressure and occasional resets.
        for (int b = 0; b < 15; b++) begin
            rp = int'($urandom_range(0, 100));
            for (int i = 0; i < 200; i++) begin
                r = ($urandom_range(0, 299) == 0);
                case ($urandom_range(0, 9))
                    0:       vv = -32768;
                    1:       vv = 30;
                    2:       vv = 29;
                    default: vv = int'($urandom_range(0, 80)) - 20;
                endcase
                cyc(r, $urandom_range(0, 7) != 0, int'($urandom_range(0, 99)) < rp, vv,
                    int'($urandom_range(0, 65535)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
